fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode-stage branch-resolve logic.
- Holds the PC and drives the instruction-memory address.
- Statically predicts beq/bne and j/jal as taken, and jr as fall-through.
- Accepts the miss/rpc redirect from the decode stage and squashes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding written into IF/ID on squash or reset (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  from hazard unit: hold PC and IF/ID contents
- miss  input  1  decode-stage mispredict: redirect fetch to rpc
- rpc  input  32  decode-stage correct PC
- imem_addr  output  32  instruction-memory address; combinational, equal to the PC register
- imem_rdata  input  32  instruction word at imem_addr; combinational read, valid same cycle
- id_instr  output  32  IF/ID instruction register
- id_pc  output  32  IF/ID PC of id_instr
- id_valid  output  1  IF/ID holds a real (non-squashed) instruction
- pred_pc  output  32  combinational next-PC prediction for the current fetch (debug/trace)

Behaviour:
- Reset (sync): pc<=RESET_PC, id_instr<=NOP_INSTR, id_pc<=0, id_valid<=0; perf counters (if present) <=0.
- Prediction decode on imem_rdata, with pc4=pc+4:
  - opcode 000010/000011 (j/jal): pred={pc4[31:28], rdata[25:0], 2'b00}.
  - opcode 000100/000101 (beq/bne): pred=pc4 + (sign-extended rdata[15:0] << 2), 32-bit wrap-around.
  - Everything else, including jr: pred=pc4.
- Priority per posedge (highest first):
  1. reset.
  2. miss=1: pc<=rpc, id_instr<=NOP_INSTR, id_valid<=0, id_pc<=rpc. Miss overrides stall, because the decode instruction is wrong-path-free and the fetched instruction is discarded.
  3. stall=1: pc, id_instr, id_pc and id_valid all hold.
  4. Normal: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pred.
- Latency: an instruction fetched in cycle N is visible on id_* in cycle N+1.
- Redirect penalty: exactly one bubble; the instruction fetched at rpc appears in IF/ID two cycles after miss is sampled.
- miss on consecutive cycles: each one applies the newest rpc and inserts a bubble.
- The reset value of pc is not predicted from; the first fetch after reset uses RESET_PC.
- No state machine beyond the PC/IF-ID registers.
- miss/rpc are ignored during reset.
- PC arithmetic is modulo 2^32; there is no alignment check (the low 2 bits propagate unchanged).

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add output ports perf_fetched[31:0] and perf_squashed[31:0]:
  - perf_fetched increments on every cycle in the Normal case.
  - perf_squashed increments on every cycle with miss=1 (not in reset).
  - Both are cleared by reset and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0, then release; imem returns 0x00000000 → imem_addr sequence 0x0, 0x4, 0x8; id_valid goes 0→1 one cycle after release; id_pc=0x0 in the first valid cycle.
2. At pc=0x10, imem=0x10000003 (beq +3) → next imem_addr=0x20; id_instr=0x10000003, id_pc=0x10.
3. At pc=0x10, imem=0x08000040 (j 0x100) → next imem_addr=0x100. At pc=0x100, imem=0x03E00008 (jr $ra) → next imem_addr=0x104.
4. miss=1, rpc=0x14, stall=1 in the same cycle → next imem_addr=0x14, id_instr=NOP_INSTR, id_valid=0; the following cycle id_pc=0x14, id_valid=1.
5. stall held 3 cycles at pc=0x8 → imem_addr stays 0x8 and id_* unchanged for 3 cycles; advances to pred on the cycle stall drops.
6. FETCH_PERF_EN defined: 5 normal cycles, 2 miss cycles, 1 stall cycle → perf_fetched=5, perf_squashed=2; assert reset → both read 0 the next cycle.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect inputs, imem port and IF/ID outputs.
// With FETCH_PERF_EN defined the bundle also carries the perf counter outputs.
interface fetch_stage_if;
    logic        stall;
    logic        miss;
    logic [31:0] rpc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] pred_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    modport master (
        input  stall, miss, rpc, imem_rdata,
        output imem_addr, id_instr, id_pc, id_valid, pred_pc
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_squashed
`endif
    );

    modport slave (
        output stall, miss, rpc, imem_rdata,
        input  imem_addr, id_instr, id_pc, id_valid, pred_pc
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_squashed
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with static prediction (j/jal, beq/bne taken) and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetched/squashed counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_id_instr;
    logic [XLEN-1:0] r_id_pc;
    logic            r_id_valid;

    logic [5:0]      w_opcode;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_br_off;
    logic [XLEN-1:0] w_pred;

    // Static next-PC prediction from the word being fetched this cycle
    always_comb begin
        w_opcode = bus.imem_rdata[31:26];
        w_pc4    = r_pc + XLEN'(4);
        w_br_off = {{14{bus.imem_rdata[15]}}, bus.imem_rdata[15:0], 2'b00};
        w_pred   = w_pc4;
        case (w_opcode)
            OP_J, OP_JAL:   w_pred = {w_pc4[31:28], bus.imem_rdata[25:0], 2'b00};
            OP_BEQ, OP_BNE: w_pred = w_pc4 + w_br_off;
            default:        w_pred = w_pc4;
        endcase
    end

    // Redirect beats stall: the fetched word is wrong-path and gets dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (bus.miss) begin
            r_pc       <= bus.rpc;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= bus.rpc;
            r_id_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_pc       <= w_pred;
            r_id_instr <= bus.imem_rdata;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
        end
    end

    assign bus.imem_addr = r_pc;
    assign bus.pred_pc   = w_pred;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc     = r_id_pc;
    assign bus.id_valid  = r_id_valid;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] r_perf_fetched;
    logic [XLEN-1:0] r_perf_squashed;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched  <= '0;
            r_perf_squashed <= '0;
        end else begin
            if (bus.miss) begin
                if (r_perf_squashed != '1) r_perf_squashed <= r_perf_squashed + XLEN'(1);
            end else if (!bus.stall) begin
                if (r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + XLEN'(1);
            end
        end
    end

    assign bus.perf_fetched  = r_perf_fetched;
    assign bus.perf_squashed = r_perf_squashed;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; perf checks run when FETCH_PERF_EN is defined.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic ms, input logic [31:0] rp, input logic [31:0] rd);
        bus.stall = st; bus.miss = ms; bus.rpc = rp; bus.imem_rdata = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.imem_addr, 32'h0); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.id_valid); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", bus.id_instr, 32'h0); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_idpc got=%h exp=%h", bus.id_pc, 32'h0); end
        // miss/rpc must be ignored while reset is asserted
        drive(1'b0, 1'b1, 32'h50, 32'h0);
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_miss_pc got=%h exp=%h", bus.imem_addr, 32'h0); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_miss_idpc got=%h exp=%h", bus.id_pc, 32'h0); end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL seq_pc1 got=%h exp=%h", bus.imem_addr, 32'h4); end
        checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid1 got=%b exp=1", bus.id_valid); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL seq_idpc1 got=%h exp=%h", bus.id_pc, 32'h0); end
        checks++; if (bus.pred_pc !== 32'h8) begin errors++; $display("FAIL seq_pred got=%h exp=%h", bus.pred_pc, 32'h8); end
        tick();
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL seq_pc2 got=%h exp=%h", bus.imem_addr, 32'h8); end
        checks++; if (bus.id_pc !== 32'h4) begin errors++; $display("FAIL seq_idpc2 got=%h exp=%h", bus.id_pc, 32'h4); end
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h1000_0003);
        #1;
        checks++; if (bus.pred_pc !== 32'h20) begin errors++; $display("FAIL beq_pred got=%h exp=%h", bus.pred_pc, 32'h20); end
        tick();
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL beq_pc got=%h exp=%h", bus.imem_addr, 32'h20); end
        checks++; if (bus.id_instr !== 32'h1000_0003) begin errors++; $display("FAIL beq_instr got=%h exp=%h", bus.id_instr, 32'h1000_0003); end
        checks++; if (bus.id_pc !== 32'h10) begin errors++; $display("FAIL beq_idpc got=%h exp=%h", bus.id_pc, 32'h10); end
        // bne with offset -1 at 0x20 loops back onto itself
        drive(1'b0, 1'b0, 32'h0, 32'h1400_FFFF);
        tick();
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("FAIL bne_neg_pc got=%h exp=%h", bus.imem_addr, 32'h20); end
    endtask

    task automatic test_jump();
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0800_0040);
        tick();
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL j_pc got=%h exp=%h", bus.imem_addr, 32'h100); end
        drive(1'b0, 1'b0, 32'h0, 32'h03E0_0008);
        tick();
        checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL jr_pc got=%h exp=%h", bus.imem_addr, 32'h104); end
        checks++; if (bus.id_instr !== 32'h03E0_0008) begin errors++; $display("FAIL jr_instr got=%h exp=%h", bus.id_instr, 32'h03E0_0008); end
        // jal keeps the upper nibble of pc+4
        drive(1'b0, 1'b1, 32'hF000_0010, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0C00_0040);
        tick();
        checks++; if (bus.imem_addr !== 32'hF000_0100) begin errors++; $display("FAIL jal_hi_pc got=%h exp=%h", bus.imem_addr, 32'hF000_0100); end
        // 32-bit wrap and unaligned propagation
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", bus.imem_addr, 32'h0); end
        drive(1'b0, 1'b1, 32'h13, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checks++; if (bus.imem_addr !== 32'h17) begin errors++; $display("FAIL unaligned_pc got=%h exp=%h", bus.imem_addr, 32'h17); end
    endtask

    task automatic test_miss_over_stall();
        drive(1'b1, 1'b1, 32'h14, 32'h0022_1820);
        tick();
        checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL ms_pc got=%h exp=%h", bus.imem_addr, 32'h14); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL ms_instr got=%h exp=%h", bus.id_instr, 32'h0); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL ms_valid got=%b exp=0", bus.id_valid); end
        drive(1'b0, 1'b0, 32'h0, 32'h0022_1820);
        tick();
        checks++; if (bus.id_pc !== 32'h14) begin errors++; $display("FAIL ms_next_idpc got=%h exp=%h", bus.id_pc, 32'h14); end
        checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL ms_next_valid got=%b exp=1", bus.id_valid); end
        checks++; if (bus.id_instr !== 32'h0022_1820) begin errors++; $display("FAIL ms_next_instr got=%h exp=%h", bus.id_instr, 32'h0022_1820); end
    endtask

    task automatic test_back_to_back_miss();
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h80, 32'h0);
        tick();
        checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL b2b_pc got=%h exp=%h", bus.imem_addr, 32'h80); end
        checks++; if (bus.id_pc !== 32'h80) begin errors++; $display("FAIL b2b_idpc got=%h exp=%h", bus.id_pc, 32'h80); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got=%b exp=0", bus.id_valid); end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 32'h4, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0022_1820);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h1000_0003);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.imem_addr, 32'h8); end
            checks++; if (bus.id_instr !== 32'h0022_1820 || bus.id_pc !== 32'h4 || bus.id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_id[%0d] got=%h/%h/%b exp=%h/%h/1", i, bus.id_instr, bus.id_pc, bus.id_valid, 32'h0022_1820, 32'h4);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h1000_0003);
        tick();
        checks++; if (bus.imem_addr !== 32'h18) begin errors++; $display("FAIL unstall_pc got=%h exp=%h", bus.imem_addr, 32'h18); end
        checks++; if (bus.id_pc !== 32'h8) begin errors++; $display("FAIL unstall_idpc got=%h exp=%h", bus.id_pc, 32'h8); end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        checks++; if (bus.perf_fetched !== 32'h0 || bus.perf_squashed !== 32'h0) begin
            errors++; $display("FAIL perf_init got=%0d/%0d exp=0/0", bus.perf_fetched, bus.perf_squashed);
        end
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b1, 32'h20, 32'h0);
        tick(); tick();
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus.perf_fetched !== 32'd5) begin errors++; $display("FAIL perf_fetched got=%0d exp=5", bus.perf_fetched); end
        checks++; if (bus.perf_squashed !== 32'd2) begin errors++; $display("FAIL perf_squashed got=%0d exp=2", bus.perf_squashed); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.perf_fetched !== 32'h0 || bus.perf_squashed !== 32'h0) begin
            errors++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", bus.perf_fetched, bus.perf_squashed);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_branch();
        test_jump();
        test_miss_over_stall();
        test_back_to_back_miss();
        test_stall();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
